// File: rtl/cpu65_pkg.sv
// cpu65 bus arbiter shared types and constants.
// State encoding, counter width and output reset values.
package cpu65_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STALL = 3'd1,
        GRANT = 3'd2,
        TURN  = 3'd3,
        COOL  = 3'd4
    } arb_state_e;

    localparam int CNT_W = 16;

    localparam logic RDY_RST = 1'b1;
    localparam logic AEC_RST = 1'b1;

endpackage

// File: rtl/cpu65_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module cpu65_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear, else increment unless saturated
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu65_bus_arbiter.sv
// Shares the cpu65 bus between the CPU and one secondary master.
// Optional perf counters: define CPU65_ARB_PERF_EN.
module cpu65_bus_arbiter
    import cpu65_pkg::*;
#(
    parameter int MAX_BURST  = 64,
    parameter int CPU_MIN    = 4,
    parameter int STALL_WAIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cpu_rwn,
    input  logic        dma_req,
    input  logic        dma_last,
    output logic        rdy,
    output logic        aec,
    output logic        dma_gnt,
    output logic        busy,
    output logic        stall_timeout
`ifdef CPU65_ARB_PERF_EN
    ,
    output logic [31:0] perf_grant_cycles,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] BURST_LAST =
        CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] COOL_LAST =
        CNT_W'((CPU_MIN > 0) ? CPU_MIN - 1 : 0);
    localparam logic [CNT_W-1:0] STALL_LIM =
        CNT_W'(STALL_WAIT);

    arb_state_e r_state;
    arb_state_e w_next;

    logic w_rdy;
    logic w_aec;
    logic w_gnt;
    logic w_busy;
    logic w_to;

    logic [CNT_W-1:0] w_burst;
    logic [CNT_W-1:0] w_cool;
    logic [CNT_W-1:0] w_stall;

    cpu65_arb_sat_cnt #(.W(CNT_W)) u_burst_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_clr (r_state != GRANT),
        .i_inc (r_state == GRANT),
        .o_cnt (w_burst)
    );

    cpu65_arb_sat_cnt #(.W(CNT_W)) u_cool_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_clr (r_state != COOL),
        .i_inc (r_state == COOL),
        .o_cnt (w_cool)
    );

    cpu65_arb_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_clr (r_state != STALL),
        .i_inc (r_state == STALL),
        .o_cnt (w_stall)
    );

`ifdef CPU65_ARB_PERF_EN
    cpu65_arb_sat_cnt #(.W(32)) u_perf_grant (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (r_state == GRANT),
        .o_cnt (perf_grant_cycles)
    );

    cpu65_arb_sat_cnt #(.W(32)) u_perf_stall (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (r_state == STALL),
        .o_cnt (perf_stall_cycles)
    );
`endif

    // Next state and next registered outputs
    always_comb begin
        w_next = r_state;
        w_to   = 1'b0;
        case (r_state)
            IDLE: begin
                if (dma_req) begin
                    w_next = STALL;
                end
            end
            STALL: begin
                if (!dma_req) begin
                    w_next = IDLE;
                end else if (cpu_rwn) begin
                    w_next = GRANT;
                end else if (w_stall == STALL_LIM) begin
                    w_to = 1'b1;
                end
            end
            GRANT: begin
                if (dma_last || !dma_req ||
                    (w_burst == BURST_LAST)) begin
                    w_next = TURN;
                end
            end
            TURN: begin
                w_next = (CPU_MIN == 0) ? IDLE : COOL;
            end
            COOL: begin
                if (w_cool == COOL_LAST) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        w_gnt  = (w_next == GRANT);
        w_aec  = !w_gnt;
        w_rdy  = !((w_next == STALL) ||
                   (w_next == GRANT) ||
                   (w_next == TURN));
        w_busy = (w_next != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            rdy           <= RDY_RST;
            aec           <= AEC_RST;
            dma_gnt       <= 1'b0;
            busy          <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            rdy           <= w_rdy;
            aec           <= w_aec;
            dma_gnt       <= w_gnt;
            busy          <= w_busy;
            stall_timeout <= w_to;
        end
    end

endmodule

// File: tb/tb_cpu65_bus_arbiter.sv
// Randomized scoreboard bench for cpu65_bus_arbiter.
// Expected cycle timelines are built from the arbitration rules.
module tb_cpu65_bus_arbiter;

    localparam int MAXB  = 8;
    localparam int CMIN  = 4;
    localparam int SWAIT = 3;

    // rdy, aec, dma_gnt, busy, stall_timeout
    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b01010;
    localparam logic [4:0] O_GRANT = 5'b00110;
    localparam logic [4:0] O_TURN  = 5'b01010;
    localparam logic [4:0] O_COOL  = 5'b11010;

    logic clk_i    = 1'b0;
    logic rst_n    = 1'b0;
    logic cpu_rwn  = 1'b1;
    logic dma_req  = 1'b0;
    logic dma_last = 1'b0;
    logic rdy;
    logic aec;
    logic dma_gnt;
    logic busy;
    logic stall_timeout;
`ifdef CPU65_ARB_PERF_EN
    logic [31:0] perf_grant_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    typedef struct packed {
        logic [4:0]  o;
        logic [31:0] pg;
        logic [31:0] ps;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   m_grant = 0;
    int   m_stall = 0;

    cpu65_bus_arbiter #(
        .MAX_BURST  (MAXB),
        .CPU_MIN    (CMIN),
        .STALL_WAIT (SWAIT)
    ) dut (
        .clk_i             (clk_i),
        .rst_n             (rst_n),
        .cpu_rwn           (cpu_rwn),
        .dma_req           (dma_req),
        .dma_last          (dma_last),
        .rdy               (rdy),
        .aec               (aec),
        .dma_gnt           (dma_gnt),
        .busy              (busy),
        .stall_timeout     (stall_timeout)
`ifdef CPU65_ARB_PERF_EN
        ,
        .perf_grant_cycles (perf_grant_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, rdy, aec, dma_gnt, busy, stall_timeout};
    endfunction

    // One bus cycle: drive its inputs and queue its expected outputs.
    task automatic cyc(input logic req, input logic last,
                       input logic rwn, input logic [4:0] o,
                       input bit is_g, input bit is_s);
        exp_t e;
        @(posedge clk_i);
        #1;
        dma_req  = req;
        dma_last = last;
        cpu_rwn  = rwn;
        e.o  = o;
        e.pg = 32'(m_grant);
        e.ps = 32'(m_stall);
        sb.push_back(e);
        if (is_g) m_grant++;
        if (is_s) m_stall++;
    endtask

    // One request episode starting with the arbiter idle.
    // mode 0: end with dma_last, 1: withdraw, 2: hold past the cap.
    task automatic episode(input int gap, input int writes,
                           input int abort_at, input int len,
                           input int mode, input bit hold);
        int   s;
        int   ng;
        logic rw;
        logic ab;
        logic endc;
        logic [4:0] o;
        for (int i = 0; i < gap; i++)
            cyc(1'b0, rb(), rb(), O_IDLE, 0, 0);
        cyc(1'b1, rb(), rb(), O_IDLE, 0, 0);
        s  = 1;
        rw = 1'b0;
        while (!rw) begin
            rw = (s > writes);
            ab = (s == abort_at);
            o  = O_STALL;
            if (s == SWAIT + 2) o[0] = 1'b1;
            cyc(!ab, rb(), rw, o, 0, 1);
            if (ab) return;
            s++;
        end
        ng = (mode == 2 || len > MAXB) ? MAXB : len;
        for (int k = 1; k <= ng; k++) begin
            endc = (mode != 2) && (k == len);
            cyc(!(endc && mode == 1), endc && mode == 0,
                rb(), O_GRANT, 1, 0);
        end
        cyc(hold ? 1'b1 : rb(), rb(), rb(), O_TURN, 0, 0);
        for (int c = 0; c < CMIN; c++)
            cyc(hold ? 1'b1 : rb(), rb(), rb(), O_COOL, 0, 0);
    endtask

    // Monitor: compare each queued cycle against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("outputs", outs(), {27'd0, e.o});
                check("gnt_excl", {30'd0, dma_gnt & aec,
                      dma_gnt & ~rdy ^ dma_gnt}, 32'd0);
`ifdef CPU65_ARB_PERF_EN
                check("perf_grant", perf_grant_cycles, e.pg);
                check("perf_stall", perf_stall_cycles, e.ps);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, n_fail=%0d",
                 n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ab;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", outs(), {27'd0, O_IDLE});
        #3;
        rst_n = 1'b1;

        episode(1, 0, 0, 0, 2, 1);
        episode(0, 0, 0, 0, 2, 1);
        episode(0, 0, 0, 3, 0, 0);
        episode(2, 0, 0, 4, 0, 0);
        episode(1, 3, 0, 2, 0, 0);
        episode(1, 4, 0, 2, 1, 0);
        episode(1, 2, 2, 1, 0, 0);
        episode(0, 0, 1, 1, 0, 0);
        episode(0, 5, 6, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            w  = $urandom_range(0, 5);
            ab = ($urandom_range(0, 3) == 0) ?
                 $urandom_range(1, w + 1) : 0;
            episode($urandom_range(0, 3), w, ab,
                    $urandom_range(1, 12),
                    $urandom_range(0, 2), rb());
        end

        cyc(1'b1, 1'b0, 1'b1, O_IDLE, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, O_STALL, 0, 1);
        cyc(1'b1, 1'b0, 1'b1, O_GRANT, 1, 0);
        cyc(1'b1, 1'b0, 1'b1, O_GRANT, 1, 0);
        @(negedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), {27'd0, O_IDLE});
        dma_req = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_hold", outs(), {27'd0, O_IDLE});
`ifdef CPU65_ARB_PERF_EN
        check("perf_rst_g", perf_grant_cycles, 32'd0);
        check("perf_rst_s", perf_stall_cycles, 32'd0);
`endif
        m_grant = 0;
        m_stall = 0;
        #5;
        rst_n = 1'b1;
        episode(1, 0, 0, 4, 0, 0);

        repeat (2) @(posedge clk_i);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu65_bus_arbiter.md
Name: cpu65_bus_arbiter

Overview:
- Shares the cpu65 address/data bus between the CPU and one secondary bus master (DMA/video fetch).
- Drives the CPU's RDY and AEC pins to do this.
- Stalls the CPU with RDY. Waits until the CPU is parked on a read cycle, because RDY does not halt writes when rdy_writes=0. Then floats the CPU bus with AEC and grants it to the requester.
- Caps burst length and guarantees the CPU a minimum window between bursts.

Parameters:
- MAX_BURST, 64: max consecutive granted cycles per burst (1..65535).
- CPU_MIN, 4: CPU-owned cycles enforced after every burst before a new grant (0 = none).
- STALL_WAIT, 3: max cycles in STALL before stall_timeout pulses. The 6502 issues at most 3 consecutive writes.

Ports:
- clk_i  in  1  system clock; same clock as cpu65 PH0IN.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_rwn  in  1  CPU RWn for the current cycle (1 = read).
- dma_req  in  1  requester wants the bus; level, held until granted or withdrawn.
- dma_last  in  1  requester's final bus cycle; sampled while dma_gnt=1.
- rdy  out  1  to CPU RDY.
- aec  out  1  to CPU AEC (0 = CPU bus outputs tristated).
- dma_gnt  out  1  requester owns the bus this cycle.
- busy  out  1  state != IDLE.
- stall_timeout  out  1  one-cycle pulse: STALL lasted more than STALL_WAIT cycles.

Behaviour:
- All outputs are registered. Async reset values: rdy=1, aec=1, dma_gnt=0, busy=0, stall_timeout=0, state=IDLE, all counters 0.
- States: IDLE, STALL, GRANT, TURN, COOL.
- IDLE
  - dma_req=1 -> STALL. rdy goes low the next cycle.
- STALL (rdy=0, aec=1)
  - A cycle with rdy=0 and cpu_rwn=1 means the CPU is halted -> GRANT next cycle. Request-to-grant latency is minimum 2 cycles.
  - dma_req=0 before grant -> abort to IDLE; rdy=1 next cycle; no COOL.
  - The stall counter counts cycles in STALL. When it exceeds STALL_WAIT, pulse stall_timeout once and keep waiting; never grant during a write.
- GRANT (rdy=0, aec=0, dma_gnt=1)
  - The burst counter increments each cycle.
  - Exit to TURN on whichever comes first: dma_last=1, dma_req=0, or burst count == MAX_BURST.
  - The exit cycle itself is still granted.
- TURN (rdy=0, aec=1, dma_gnt=0)
  - One-cycle bus turnaround so the CPU re-drives address before resuming.
  - -> COOL, or -> IDLE if CPU_MIN=0.
- COOL (rdy=1, aec=1)
  - Counts CPU_MIN cycles, then -> IDLE.
  - dma_req is ignored here; it is sampled again in IDLE. Back-to-back requesters therefore see at least CPU_MIN+1 CPU cycles between bursts.
- The burst and cool counters are 16 bits and clear on entry to their state; no wrap is possible.
- dma_gnt and aec are never both high; dma_gnt=1 implies rdy=0.
- Reset asserted mid-burst: all outputs take reset values immediately (async). The requester must treat the loss of dma_gnt as an abort.
- dma_last without dma_req outside GRANT is ignored.

Optional Feature:
- Macro CPU65_ARB_PERF_EN.
- When defined, adds outputs perf_grant_cycles[31:0] and perf_stall_cycles[31:0]:
  - Free-running counters of GRANT and STALL cycles.
  - Saturate at 0xFFFFFFFF; cleared only by rst_n.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu65_pkg holds:
  - state enum (IDLE=0, STALL=1, GRANT=2, TURN=3, COOL=4), 3 bits;
  - localparam CNT_W=16;
  - the reset value constants for rdy and aec.
- One sub-module: cpu65_arb_sat_cnt, a saturating up-counter with clear. It is reused for the burst, cool, stall and perf counters.
- FSM and output registers stay in the top.

Test Plan:
- Read-cycle stall: with cpu_rwn=1, pulse dma_req at cycle t.
  - rdy=0 at t+1; dma_gnt=1, aec=0 at t+2.
  - dma_last at t+5 -> TURN at t+6 (aec=1, rdy=0), rdy=1 at t+7.
- Write-in-progress: cpu_rwn=0 for 3 cycles after rdy falls.
  - No grant until the first cpu_rwn=1 cycle; stall_timeout stays 0.
  - A 4th write cycle produces a stall_timeout pulse and still no grant.
- Burst cap: MAX_BURST=8, dma_req held high, no dma_last.
  - Exactly 8 dma_gnt cycles, then TURN, then CPU_MIN=4 cycles with rdy=1, then a re-grant sequence.
- Abort: dma_req falls while in STALL -> rdy=1 next cycle, dma_gnt never asserts, busy=0.
- Async reset mid-GRANT: rst_n low between clock edges.
  - rdy=1, aec=1, dma_gnt=0 without waiting for a clock edge.
  - After release, a fresh request behaves as in the read-cycle stall case.
- CPU65_ARB_PERF_EN: the burst cap run gives perf_grant_cycles=8 after one burst and 16 after two.
